// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial chunk adder.
//
// Contents:
//   state_e   : controller states (IDLE, BUSY, DONE).
//   cnt_width : chunk-counter width, clog2(nchunk) but never less than 1 bit.
//
// Optional feature macro honoured by the files that import this package:
//   SERIAL_ADDER_SUB_EN (adds a subtract control input).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int nchunk);
    int w;
    w = $clog2(nchunk);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Handshake/data bundle for the serial chunk adder.
//
// Signals:
//   in_valid, in_ready : input handshake; a, b, cin (and sub) travel with it.
//   out_valid, out_ready : output handshake; sum, cout, ovf travel with it.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer keeps its data steady while
// valid is high, and the consumer may hold ready low for any number of cycles.
//
// Modports:
//   master : the side that supplies operands and consumes results.
//   slave  : the adder itself.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 1-bit 'sub' input.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder used for one slice per clock.
//
// Ports:
//   x, y   : CHUNK-bit addends
//   ci     : carry into bit 0
//   s      : CHUNK-bit sum
//   co     : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow detection)
module chunk_ripple_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // One procedural loop keeps the carry chain in a single block so the
  // bit-to-bit dependency is ordered explicitly.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands are added CHUNK bits per clock with a
// registered carry linking consecutive chunks.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of serial_chunk_adder_if (operands in, result out)
//   dbg_state : current controller state
//
// Operation: IDLE accepts an operand set, BUSY spends NCHUNK cycles adding
// one chunk per cycle (LSB chunk first), DONE presents the frozen result until
// the consumer takes it.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN. When defined, bus.sub = 1
// computes a - b (B inverted at latch time, carry forced to 1, cin ignored).
module serial_chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_chunk_adder_if.slave   bus,
  output state_e                dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               sub_in;
  logic               last_chunk;
  logic [CHUNK-1:0]   chunk_s;
  logic               chunk_co;
  logic               chunk_c_msb;
  logic [WIDTH+CHUNK-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  chunk_ripple_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x     (a_q[CHUNK-1:0]),
    .y     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_c_msb)
  );

  // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the LSB.
  // Built on a wider vector so the NCHUNK == 1 case needs no empty slice.
  assign sum_shift = {chunk_s, sum_q};

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_chunk)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          // Subtraction is a + ~b + 1: invert B here and force the carry in.
          b_d     = bus.b ^ {WIDTH{sub_in}};
          carry_d = sub_in | bus.cin;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_shift[WIDTH+CHUNK-1:CHUNK];
        carry_d = chunk_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_chunk) begin
          cout_d = chunk_co;
          ovf_d  = chunk_co ^ chunk_c_msb;
        end
      end
      default: ;
    endcase
  end

  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule
